sixty_ctrl: RTL and testbench

//   Run/stop/set controller for the 00-59 seconds display: sequences a units
//   (mod-ONES_MOD) and tens (mod-TENS_MOD) BCD digit pair from a one-cycle tick

---
 rtl/sixty_ctrl.sv | 95 +++++++++
 tb/tb_sixty_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sixty_ctrl.sv
// Seconds-stage run/stop/set controller: BCD units/tens pair counting 00..59
// from a one-cycle tick, with minute carry and range-guarded digit loads.
module sixty_ctrl #(
  parameter int ONES_MOD = 10,
  parameter int TENS_MOD = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       set_en,
  input  logic [3:0] set_tens,
  input  logic [3:0] set_ones,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       carry,
  output logic       running,
  output logic       set_err
);

  localparam logic [3:0] ONES_MAX = 4'(ONES_MOD - 1);
  localparam logic [3:0] TENS_MAX = 4'(TENS_MOD - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     r_state;
  logic [3:0] r_ones;
  logic [3:0] r_tens;
  logic       r_carry;
  logic       r_running;
  logic       r_set_err;

  logic w_set_ok;
  logic w_ones_wrap;
  logic w_tens_wrap;

  assign w_set_ok    = (r_state == IDLE) &&
                       (set_ones <= ONES_MAX) &&
                       (set_tens <= TENS_MAX);
  assign w_ones_wrap = (r_ones == ONES_MAX);
  assign w_tens_wrap = (r_tens == TENS_MAX);

  // Strict priority chain: a higher input masks every lower one this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ones    <= 4'd0;
      r_tens    <= 4'd0;
      r_carry   <= 1'b0;
      r_running <= 1'b0;
      r_set_err <= 1'b0;
    end else begin
      r_carry   <= 1'b0;
      r_set_err <= 1'b0;
      if (clear) begin
        r_ones <= 4'd0;
        r_tens <= 4'd0;
      end else if (set_en) begin
        if (w_set_ok) begin
          r_ones <= set_ones;
          r_tens <= set_tens;
        end else begin
          r_set_err <= 1'b1;
        end
      end else if (stop) begin
        r_state   <= IDLE;
        r_running <= 1'b0;
      end else if (start) begin
        r_state   <= RUN;
        r_running <= 1'b1;
      end else if (tick && r_state == RUN) begin
        if (w_ones_wrap) begin
          r_ones <= 4'd0;
          if (w_tens_wrap) begin
            r_tens  <= 4'd0;
            r_carry <= 1'b1;
          end else begin
            r_tens <= r_tens + 4'd1;
          end
        end else begin
          r_ones <= r_ones + 4'd1;
        end
      end
    end
  end

  assign ones    = r_ones;
  assign tens    = r_tens;
  assign carry   = r_carry;
  assign running = r_running;
  assign set_err = r_set_err;

endmodule

// File: tb/tb_sixty_ctrl.sv
// Scoreboard bench for sixty_ctrl: a seconds-count reference model queues
// the expected outputs per cycle; a negedge monitor pops and compares.
module tb_sixty_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       set_en = 1'b0;
  logic [3:0] set_tens = 4'd0;
  logic [3:0] set_ones = 4'd0;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       carry;
  logic       running;
  logic       set_err;

  typedef struct {
    int ones;
    int tens;
    bit carry;
    bit running;
    bit set_err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  int   m_sec = 0;
  bit   m_run = 1'b0;

  sixty_ctrl #(.ONES_MOD(10), .TENS_MOD(6)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .start(start), .stop(stop), .clear(clear),
    .set_en(set_en), .set_tens(set_tens), .set_ones(set_ones),
    .ones(ones), .tens(tens), .carry(carry),
    .running(running), .set_err(set_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t",
               name, act, req, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("ones", int'(ones), e.ones);
        chk("tens", int'(tens), e.tens);
        chk("carry", int'(carry), int'(e.carry));
        chk("running", int'(running), int'(e.running));
        chk("set_err", int'(set_err), int'(e.set_err));
      end
    end
  end

  // Reference: value held as a plain seconds count 0..59.
  task automatic step(bit r, bit t, bit sta, bit sto, bit clr,
                      bit se, int st, int so);
    exp_t e;
    rst = r; tick = t; start = sta; stop = sto;
    clear = clr; set_en = se;
    set_tens = 4'(st); set_ones = 4'(so);
    e.carry = 1'b0;
    e.set_err = 1'b0;
    if (r) begin
      m_sec = 0;
      m_run = 1'b0;
    end else if (clr) begin
      m_sec = 0;
    end else if (se) begin
      if (!m_run && so < 10 && st < 6) m_sec = st * 10 + so;
      else e.set_err = 1'b1;
    end else if (sto) begin
      m_run = 1'b0;
    end else if (sta) begin
      m_run = 1'b1;
    end else if (t && m_run) begin
      if (m_sec == 59) begin
        m_sec = 0;
        e.carry = 1'b1;
      end else begin
        m_sec++;
      end
    end
    e.ones = m_sec % 10;
    e.tens = m_sec / 10;
    e.running = m_run;
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_set(int st, int so);
    step(0, 0, 0, 0, 0, 1, st, so);
  endtask

  initial begin
    int budget;
    @(posedge clk);
    #1;
    // reset, then ticks while IDLE are ignored
    step(1, 0, 0, 0, 0, 0, 0, 0);
    ticks(3);
    // start, ten ticks: 09 then 10 without carry
    step(0, 1, 1, 0, 0, 0, 0, 0);
    ticks(10);
    // set 58, run to 59 then wrap with carry
    step(0, 0, 0, 1, 0, 0, 0, 0);
    do_set(5, 8);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    ticks(2);
    idle(2);
    // rejected loads: range in IDLE, any load in RUN
    step(0, 0, 0, 1, 0, 0, 0, 0);
    do_set(0, 10);
    do_set(6, 0);
    do_set(15, 15);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    do_set(2, 3);
    idle(1);
    // stop+tick and start+tick are not counted
    step(0, 0, 0, 1, 0, 0, 0, 0);
    do_set(4, 2);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0);
    ticks(1);
    step(0, 1, 1, 1, 0, 0, 0, 0);
    // clear beats tick at 59; clear beats set; rst mid-RUN
    do_set(5, 9);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    do_set(3, 3);
    step(0, 0, 0, 0, 1, 1, 9, 9);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    ticks(75);
    step(1, 1, 1, 0, 0, 0, 0, 0);
    idle(1);
    // randomized traffic biased toward long RUN stretches
    for (int i = 0; i < 3000; i++) begin
      int p;
      p = $urandom_range(0, 999);
      step(p < 3,
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 29) == 0),
           $urandom_range(0, 15) > 8 ? $urandom_range(0, 15)
                                     : $urandom_range(0, 5),
           $urandom_range(0, 15) > 12 ? $urandom_range(0, 15)
                                      : $urandom_range(0, 9));
    end
    idle(2);
    budget = 20;
    while (q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
